// File: rtl/adam_aes_decipher_fully_pipelined_if.sv
// Handshake and data bus for the fully pipelined AES-128 inverse cipher.
// Optional statistics signals are present only with ADAM_AES_DECIPHER_STATS_EN defined.
interface adam_aes_decipher_fully_pipelined_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] block;
  logic [127:0] round_keys [0:10];
  logic         out_valid;
  logic         out_ready;
  logic [127:0] result;
  logic         idle;
`ifdef ADAM_AES_DECIPHER_STATS_EN
  logic         clr_count;
  logic [31:0]  blk_count;

  modport master (
    output in_valid, block, round_keys, out_ready, clr_count,
    input  in_ready, out_valid, result, idle, blk_count
  );
  modport slave (
    input  in_valid, block, round_keys, out_ready, clr_count,
    output in_ready, out_valid, result, idle, blk_count
  );
`else
  modport master (
    output in_valid, block, round_keys, out_ready,
    input  in_ready, out_valid, result, idle
  );
  modport slave (
    input  in_valid, block, round_keys, out_ready,
    output in_ready, out_valid, result, idle
  );
`endif
endinterface

// File: rtl/adam_aes_decipher_fully_pipelined.sv
// Fully pipelined AES-128 inverse cipher: input AddRoundKey stage, ten inverse rounds and an
// output register, one block per cycle, 11-cycle latency. The whole pipe advances or freezes
// together under a single enable derived from output backpressure.
// Optional block counter: define ADAM_AES_DECIPHER_STATS_EN.
module adam_aes_decipher_fully_pipelined #(
  parameter int unsigned NSTAGES = 12  // fixed at 12; other values are not supported
) (
  input logic                                clk,
  input logic                                reset_n,
  adam_aes_decipher_fully_pipelined_if.slave bus
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant coefficient k in GF(2^8).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return ({8{k[0]}} & a) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
  endfunction

  // Byte i of the state is bits 127-8i; row r of column c is byte 4c+r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
      o[119 - 32*c -: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
      o[111 - 32*c -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
      o[103 - 32*c -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
    end
    return o;
  endfunction

  logic [NSTAGES-1:0] v_q;
  logic [127:0]       st_d [NSTAGES-1];
  logic [127:0]       st_q [NSTAGES-1];
  logic [127:0]       res_q;
  logic               adv;

  // Only a full, blocked output stage can stall; the stall freezes every stage.
  assign adv = !(v_q[NSTAGES-1] && !bus.out_ready);

  assign st_d[0] = bus.block ^ bus.round_keys[NSTAGES-2];

  for (genvar r = 1; r < NSTAGES - 1; r++) begin : g_round
    logic [127:0] isr, isb, ark;
    assign isr = inv_shift_rows(st_q[r-1]);
    for (genvar b = 0; b < 16; b++) begin : g_sbox
      adam_aes_inv_sbox u_inv_sbox (
        .in_byte  (isr[127 - 8*b -: 8]),
        .out_byte (isb[127 - 8*b -: 8])
      );
    end
    assign ark = isb ^ bus.round_keys[NSTAGES-2-r];
    if (r == NSTAGES - 2) begin : g_last
      assign st_d[r] = ark;
    end else begin : g_mid
      assign st_d[r] = inv_mix_columns(ark);
    end
  end

  // Stage data registers 0..10; contents are don't-care while the matching valid bit is low.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int s = 0; s < NSTAGES - 1; s++) begin
        st_q[s] <= st_d[s];
      end
    end
  end

  // Valid shift register and output register; reset discards everything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q   <= '0;
      res_q <= '0;
    end else if (adv) begin
      v_q   <= {v_q[NSTAGES-2:0], bus.in_valid};
      res_q <= st_q[NSTAGES-2];
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = v_q[NSTAGES-1];
  assign bus.result    = res_q;
  assign bus.idle      = ~|v_q;

`ifdef ADAM_AES_DECIPHER_STATS_EN
  logic [31:0] cnt_q;

  // Output handshake counter; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (bus.clr_count) begin
      cnt_q <= '0;
    end else if (v_q[NSTAGES-1] && bus.out_ready) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign bus.blk_count = cnt_q;
`endif

endmodule

// AES inverse S-box, 8-bit lookup.
module adam_aes_inv_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [2047:0] InvSboxTab = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry i sits at bits 8*(255-i)+7 down, i.e. index {~i, 3'b111}.
  always_comb begin
    out_byte = InvSboxTab[{~in_byte, 3'b111} -: 8];
  end
endmodule

// File: tb/tb_adam_aes_decipher_fully_pipelined.sv
// Self-checking bench for adam_aes_decipher_fully_pipelined. Expected plaintexts come from
// FIPS-197 constants and from a forward AES-128 model built from GF(2^8) arithmetic.
module tb_adam_aes_decipher_fully_pipelined;
  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  localparam int NV = 20;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           ready_low = 0;
  int           stale = 0;
  int           popped = 0;
  string        phase = "init";
  logic [7:0]   sb [256];
  logic [127:0] rkm [0:10];
  logic [127:0] exp_q [$];
  int           acc_q [$];
  vec_t         vec [NV];

  adam_aes_decipher_fully_pipelined_if bus ();

  adam_aes_decipher_fully_pipelined #(
    .NSTAGES (12)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Forward S-box from multiplicative inverse plus affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      rkm[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      bus.round_keys[r] = rkm[r];
    end
  endtask

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = sb[s[127 - 8*(4*((c + r) % 4) + r) -: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103 - 32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rkm[0];
    for (int r = 1; r < 10; r++) s = mix_columns(sub_shift(s)) ^ rkm[r];
    return sub_shift(s) ^ rkm[10];
  endfunction

  // One cycle: drive at the negedge, settle, score handshakes, advance to the next negedge.
  task automatic drive(input logic iv, input logic [127:0] ct, input logic [127:0] pt,
                       input logic ordy, input int extra);
    logic [127:0] e;
    int           a;
    bus.in_valid  = iv;
    bus.block     = ct;
    bus.out_ready = ordy;
    #1;
    if (!bus.in_ready) ready_low++;
    if (bus.out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        stale++;
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        popped++;
        chk({phase, "_data"}, bus.result, e);
        chki({phase, "_latency"}, cyc - a, 11 + extra);
      end
    end
    if (iv && bus.in_ready) begin
      exp_q.push_back(pt);
      acc_q.push_back(cyc + 1);
    end
    @(negedge clk);
  endtask

  task automatic drain(input int extra);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) drive(1'b0, '0, '0, 1'b1, extra);
    chki({phase, "_left_in_flight"}, exp_q.size(), 0);
    chki({phase, "_stale_outputs"}, stale, 0);
    chki({phase, "_idle"}, int'(bus.idle), 1);
  endtask

  initial begin
    int           acc;
    int           p0;
    int           pat [6];
    logic [127:0] pt;
    pat = '{1, 0, 0, 1, 0, 1};
    bus.in_valid  = 1'b0;
    bus.block     = '0;
    bus.out_ready = 1'b1;
`ifdef ADAM_AES_DECIPHER_STATS_EN
    bus.clr_count = 1'b0;
`endif
    build_sbox();
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    vec[0].ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    vec[0].pt = 128'h00112233445566778899aabbccddeeff;
    for (int i = 1; i < NV; i++) begin
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      vec[i].pt = pt;
      vec[i].ct = encrypt(pt);
    end

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chki("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_result", bus.result, '0);
    chki("reset_in_ready", int'(bus.in_ready), 1);
    chki("reset_idle", int'(bus.idle), 1);
`ifdef ADAM_AES_DECIPHER_STATS_EN
    chki("reset_blk_count", int'(bus.blk_count), 0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    // FIPS-197 single block with explicit latency and idle timing.
    phase = "fips";
    bus.in_valid  = 1'b1;
    bus.block     = vec[0].ct;
    bus.out_ready = 1'b1;
    #1;
    chki("fips_in_ready", int'(bus.in_ready), 1);
    acc = cyc + 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chki("fips_busy_idle", int'(bus.idle), 0);
    while (!bus.out_valid && cyc < acc + 20) @(negedge clk);
    chki("fips_latency", cyc - acc, 11);
    chk("fips_result", bus.result, vec[0].pt);
    @(negedge clk);
    chki("fips_out_valid_after", int'(bus.out_valid), 0);
    chki("fips_idle_after", int'(bus.idle), 1);

    // Back-to-back streaming from the vector table.
    phase = "stream";
    ready_low = 0;
    stale = 0;
    p0 = popped;
    for (int i = 0; i < NV; i++) drive(1'b1, vec[i].ct, vec[i].pt, 1'b1, 0);
    drain(0);
    chki("stream_in_ready_low_cycles", ready_low, 0);
    chki("stream_blocks_out", popped - p0, NV);

    // Backpressure: 4-cycle hold once the first block reaches the output.
    phase = "bp";
    stale = 0;
    p0 = popped;
    for (int i = 0; i < 5; i++) drive(1'b1, vec[i].ct, vec[i].pt, 1'b1, 0);
    for (int k = 0; k < 20 && !bus.out_valid; k++) drive(1'b0, '0, '0, 1'b1, 0);
    chki("bp_reached_output", int'(bus.out_valid), 1);
    for (int h = 0; h < 4; h++) begin
      bus.out_ready = 1'b0;
      #1;
      chki("bp_hold_in_ready", int'(bus.in_ready), 0);
      chki("bp_hold_out_valid", int'(bus.out_valid), 1);
      chk("bp_hold_result", bus.result, vec[0].pt);
      drive(1'b0, '0, '0, 1'b0, 0);
    end
    drain(4);
    chki("bp_blocks_out", popped - p0, 5);

    // Bubbles: in_valid pattern 1,0,0,1,0,1.
    phase = "bubble";
    stale = 0;
    p0 = popped;
    for (int i = 0; i < 6; i++) begin
      drive(pat[i] != 0, vec[5+i].ct, vec[5+i].pt, 1'b1, 0);
    end
    drain(0);
    chki("bubble_blocks_out", popped - p0, 3);

    // Reset with 6 blocks in flight, the oldest already presented at the output.
    phase = "rst";
    stale = 0;
    for (int i = 0; i < 6; i++) drive(1'b1, vec[11+i].ct, vec[11+i].pt, 1'b1, 0);
    for (int k = 0; k < 20 && !bus.out_valid; k++) drive(1'b0, '0, '0, 1'b0, 0);
    chki("rst_pre_out_valid", int'(bus.out_valid), 1);
    bus.out_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    chki("rst_out_valid", int'(bus.out_valid), 0);
    chki("rst_idle", int'(bus.idle), 1);
    chk("rst_result", bus.result, '0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 16; k++) drive(1'b0, '0, '0, 1'b1, 0);
    chki("rst_no_stale_output", stale, 0);
    phase = "rst_fips";
    drive(1'b1, vec[0].ct, vec[0].pt, 1'b1, 0);
    drain(0);

    // FIPS-197 Appendix B vector under a different key schedule.
    phase = "fips_b";
    stale = 0;
    expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    drive(1'b1, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734,
          1'b1, 0);
    drain(0);

`ifdef ADAM_AES_DECIPHER_STATS_EN
    phase = "stats";
    stale = 0;
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    bus.clr_count = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 0);
    bus.clr_count = 1'b0;
    chki("stats_cleared", int'(bus.blk_count), 0);
    for (int i = 0; i < 7; i++) drive(1'b1, vec[i].ct, vec[i].pt, 1'b1, 0);
    drain(0);
    chki("stats_count_7", int'(bus.blk_count), 7);
    drive(1'b1, vec[7].ct, vec[7].pt, 1'b1, 0);
    for (int k = 0; k < 20 && !bus.out_valid; k++) drive(1'b0, '0, '0, 1'b1, 0);
    chki("stats_before_clear", int'(bus.blk_count), 7);
    bus.clr_count = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 0);
    bus.clr_count = 1'b0;
    chki("stats_clear_wins", int'(bus.blk_count), 0);
    drain(0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adam_aes_decipher_fully_pipelined.md
Name: adam_aes_decipher_fully_pipelined

Overview:
- Fully pipelined AES-128 inverse cipher. It is the decrypt counterpart of the team's pipelined encipher and sits beside it in the AES peripheral core.
- Ten inverse rounds are physically instantiated with a register between each, plus an input AddRoundKey stage and an output register.
- Uses a valid/ready handshake on both sides with per-stage valid bits. Throughput is one block per cycle; latency is 11 cycles.

Parameters:
- NSTAGES, 12, number of pipeline registers (stage 0..11). Fixed; any other value is unsupported.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  ciphertext block offered
- in_ready  out  1  block accepted when in_valid && in_ready at a rising edge
- block  in  128  ciphertext, AES byte order (byte 0 = bits 127:120)
- round_keys  in  128 x [0:10]  encryption key schedule, unmodified; decipher consumes it in reverse order
- out_valid  out  1  result holds a plaintext block
- out_ready  in  1  downstream accepts result when out_valid && out_ready
- result  out  128  plaintext
- idle  out  1  high when no stage holds a valid block

Behaviour:
- Reset values: all stage valid bits 0; out_valid=0; result=0; in_ready=1; idle=1. Datapath stage registers other than stage 11 need no reset.
- Global advance enable: adv = !(v[11] && !out_ready). in_ready = adv, combinational from out_ready and v[11].
- When adv=1, every stage shifts one step: v[0] <= in_valid; v[s] <= v[s-1]. Data moves alongside.
- When adv=0, every stage and every valid bit holds.
- Bubbles are not compressed, so a stall freezes the whole pipe.
- Stage 0: block ^ round_keys[10].
- Stages 1..9 (stage r), from stage r-1: InvShiftRows -> InvSubBytes -> AddRoundKey(round_keys[10-r]) -> InvMixColumns.
- Stage 10, from stage 9: InvShiftRows -> InvSubBytes -> AddRoundKey(round_keys[0]). No InvMixColumns.
- Stage 11: copy of stage 10. result = stage 11 register; out_valid = v[11].
- Latency: a block accepted at edge k appears with out_valid=1 after edge k+11, given no stalls. Each stall cycle adds one.
- Output hold: while out_valid && !out_ready, result and out_valid stay stable.
- Simultaneous in_valid with out_valid && out_ready: both transfers occur at the same edge, giving full throughput.
- in_valid=0 while adv=1 injects a bubble (v[0]=0). Stage data is don't-care when its valid bit is 0.
- idle = ~|v[0..11].
- round_keys must stay stable while idle=0. A key change with blocks in flight corrupts those blocks, and no detection is required.
- InvSubBytes uses 16 instances of the codebase inverse S-box (adam_aes_inv_sbox, 8-bit in/out) per stage.
- InvMixColumns is GF(2^8) with polynomial 0x11B; coefficients are 0e,0b,0d,09.
- Reset asserted mid-operation clears all valid bits asynchronously. In-flight blocks are discarded, and out_valid drops immediately.
- No FSM beyond the valid shift register. There is no start/done pulse interface.

Optional Feature:
- Macro ADAM_AES_DECIPHER_STATS_EN.
- Defined: adds output blk_count (32 bits, reset 0). It increments by 1 on every output handshake (out_valid && out_ready) and wraps 0xFFFFFFFF -> 0. It also adds input clr_count (1 bit), which synchronously zeroes the counter; clr_count takes priority over a same-cycle increment.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
- FIPS-197 AES-128 single block:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, with the expanded schedule driven on round_keys; block 69c4e0d86a7b0430d8cdb78070b4c55a; out_ready=1.
  - Required: result 00112233445566778899aabbccddeeff, with out_valid asserted exactly 11 cycles after the accept edge. idle returns to 1 one cycle after the output handshake.
- Back-to-back streaming:
  - Stimulus: 20 consecutive blocks with in_valid=1 and out_ready=1; ciphertexts produced by the reference encipher model from random plaintexts.
  - Required: 20 consecutive out_valid cycles starting at cycle 11, each matching its plaintext in order, with in_ready constantly 1.
- Backpressure:
  - Stimulus: stream 5 blocks, then hold out_ready=0 for 4 cycles once the first block has reached the output.
  - Required: in_ready=0 and result stable during the hold. All 5 blocks arrive in order with no loss or duplication, the last one 4 cycles later than the unstalled case.
- Bubbles:
  - Stimulus: in_valid pattern 1,0,0,1,0,1.
  - Required: out_valid pattern 1,0,0,1,0,1 starting at latency 11, with matching data.
- Reset mid-flight:
  - Stimulus: assert reset_n=0 for 1 cycle with 6 blocks in flight.
  - Required: out_valid=0 and idle=1 immediately, with no stale output afterwards. The next FIPS block decrypts correctly.
- STATS_EN (macro defined):
  - Stimulus: 7 output handshakes, then clr_count=1 on the same cycle as an 8th handshake.
  - Required: blk_count reads 7 before the clear, then 0 after that edge.
